// File: rtl/nh_pkg.sv
// Shared widths and writer FSM state encoding for the pixel point processor.
package nh_pkg;

    localparam int PIX_W      = 32;
    localparam int MEM_ADDR_W = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } wr_state_t;

endpackage : nh_pkg

// File: rtl/pixel_result_writer_if.sv
// Pixel handshake from the processor plus the result-memory write port.
// The master modport is the writer side; the slave modport is processor + memory.
interface pixel_result_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) ();
    logic [DATA_W-1:0] pix_data;
    logic              pix_done;
    logic              ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;

    modport master (
        input  pix_data, pix_done, mem_gnt,
        output ack, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output pix_data, pix_done, mem_gnt,
        input  ack, mem_we, mem_addr, mem_wdata
    );
endinterface : pixel_result_writer_if

// File: rtl/pixel_wb_fifo.sv
// Small synchronous FIFO buffering captured pixels ahead of the memory write port.
// Exposes the head and the entry behind it so a completing write can chain the next one.
module pixel_wb_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] next_data
);

    logic [DATA_W-1:0] store_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  rd_next_s;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rd_next_s = rd_ptr_r + PTR_W'(1);
    assign head      = store_r[rd_ptr_r];
    assign next_data = store_r[rd_next_s];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                store_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                store_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : pixel_wb_fifo

// File: rtl/pixel_result_writer.sv
// Captures finished pixels via done/ack, buffers them and writes them to sequential
// result-memory addresses. Optional ReLU at capture: define PIXEL_WRITER_RELU_EN.
module pixel_result_writer
    import nh_pkg::*;
#(
    parameter int DATA_W     = PIX_W,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      result_addr,
    input  logic [ADDR_W-1:0]      pix_count,
    output logic                   busy,
    output logic                   done,
    pixel_result_writer_if.master  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    wr_state_t         state_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ADDR_W-1:0] cap_left_r;
    logic [ADDR_W-1:0] wr_left_r;
    logic              ack_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              busy_r;
    logic              done_r;

    logic              cap_fire_s;
    logic              wr_fire_s;
    logic [DATA_W-1:0] push_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic [DATA_W-1:0] fifo_next_s;

    // Capture is blocked while ack is high so a held pix_done is never taken twice.
    assign cap_fire_s = (state_r == RUN) && bus.pix_done && !ack_r && !fifo_full_s
                        && (cap_left_r != {ADDR_W{1'b0}});
    assign wr_fire_s  = mem_we_r && bus.mem_gnt;

    assign bus.ack       = ack_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;

    // Pixel value stored at capture time.
    always_comb begin
        push_data_s = bus.pix_data;
`ifdef PIXEL_WRITER_RELU_EN
        if (bus.pix_data[DATA_W-1]) begin
            push_data_s = {DATA_W{1'b0}};
        end else begin
            push_data_s = bus.pix_data;
        end
`endif
    end

    pixel_wb_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_fire_s),
        .push_data (push_data_s),
        .pop       (wr_fire_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s),
        .next_data (fifo_next_s)
    );

    // Job FSM with capture handshake and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wr_addr_r   <= {ADDR_W{1'b0}};
            cap_left_r  <= {ADDR_W{1'b0}};
            wr_left_r   <= {ADDR_W{1'b0}};
            ack_r       <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r    <= 1'b0;
                    mem_we_r <= 1'b0;
                    done_r   <= 1'b0;
                    if (start) begin
                        wr_addr_r  <= result_addr;
                        cap_left_r <= pix_count;
                        wr_left_r  <= pix_count;
                        if (pix_count != {ADDR_W{1'b0}}) begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= FIN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    done_r <= 1'b0;
                    ack_r  <= cap_fire_s;
                    if (cap_fire_s) begin
                        cap_left_r <= cap_left_r - ADDR_ONE;
                    end
                    if (wr_fire_s) begin
                        wr_addr_r <= wr_addr_r + ADDR_ONE;
                        wr_left_r <= wr_left_r - ADDR_ONE;
                        // Chain the entry behind the one being retired, if present.
                        if (fifo_count_s >= CNT_W'(2)) begin
                            mem_addr_r  <= wr_addr_r + ADDR_ONE;
                            mem_wdata_r <= fifo_next_s;
                        end else begin
                            mem_we_r <= 1'b0;
                        end
                        if (wr_left_r == ADDR_ONE) begin
                            state_r <= FIN;
                            busy_r  <= 1'b0;
                        end
                    end else if (!mem_we_r && !fifo_empty_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= wr_addr_r;
                        mem_wdata_r <= fifo_head_s;
                    end else begin
                        mem_we_r <= mem_we_r;
                    end
                end
                FIN: begin
                    ack_r    <= 1'b0;
                    mem_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    ack_r    <= 1'b0;
                    mem_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule : pixel_result_writer

// File: tb/tb_pixel_result_writer.sv
// Directed self-checking bench for pixel_result_writer.
module tb_pixel_result_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] result_addr;
    logic [13:0] pix_count;
    logic        busy;
    logic        done;

    pixel_result_writer_if #(.DATA_W(32), .ADDR_W(14)) bus ();

    pixel_result_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .result_addr (result_addr),
        .pix_count   (pix_count),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    logic [13:0] wa_q [$];
    logic [31:0] wd_q [$];
    logic [31:0] px [0:15];
    int          px_n = 0;
    int          px_idx = 0;

    // Record every completed write and every ack/done pulse.
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_gnt) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
        end
        if (bus.ack)  ack_cnt++;
        if (done)     done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Processor model: offers px[px_idx] and advances when ack is seen.
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.ack && px_idx < px_n) px_idx++;
            if (px_idx < px_n) begin
                bus.pix_done = 1'b1;
                bus.pix_data = px[px_idx];
            end else begin
                bus.pix_done = 1'b0;
            end
        end
    endtask

    task automatic start_job(input logic [13:0] addr, input logic [13:0] cnt);
        start       = 1'b1;
        result_addr = addr;
        pix_count   = cnt;
        run_cycles(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            run_cycles(1);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    int a0, d0, w0;
    logic [31:0] relu_exp0;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        result_addr  = 14'd0;
        pix_count    = 14'd0;
        bus.pix_data = 32'd0;
        bus.pix_done = 1'b0;
        bus.mem_gnt  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(bus.ack), 32'd0);
        check("rst_we",    32'(bus.mem_we), 32'd0);
        check("rst_addr",  32'(bus.mem_addr), 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        rst_n = 1'b1;
        run_cycles(2);

        // Basic three-pixel job.
        px[0] = 32'd5; px[1] = 32'd6; px[2] = 32'd7; px_n = 3; px_idx = 0;
        a0 = ack_cnt; d0 = done_cnt; w0 = wa_q.size();
        start_job(14'd10000, 14'd3);
        check("busy_run", 32'(busy), 32'd1);
        wait_done(100);
        check("fin_busy", 32'(busy), 32'd0);
        run_cycles(3);
        check("t1_acks",  32'(ack_cnt - a0), 32'd3);
        check("t1_dones", 32'(done_cnt - d0), 32'd1);
        check("t1_nwr",   32'(wa_q.size() - w0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", 32'(wa_q[w0 + i]), 32'd10000 + 32'(i));
            check("t1_data", wd_q[w0 + i], 32'd5 + 32'(i));
        end

        // Zero-length job.
        px_n = 0; px_idx = 0;
        a0 = ack_cnt; d0 = done_cnt; w0 = wa_q.size();
        start_job(14'd50, 14'd0);
        check("t2_done_early", 32'(done), 32'd0);
        run_cycles(1);
        check("t2_done_2cyc", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        run_cycles(4);
        check("t2_done_once", 32'(done_cnt - d0), 32'd1);
        check("t2_acks", 32'(ack_cnt - a0), 32'd0);
        check("t2_nwr",  32'(wa_q.size() - w0), 32'd0);

        // Back-pressure: FIFO fills, write held stable.
        for (int i = 0; i < 8; i++) px[i] = 32'h100 + 32'(i);
        px_n = 8; px_idx = 0;
        a0 = ack_cnt; d0 = done_cnt; w0 = wa_q.size();
        bus.mem_gnt = 1'b0;
        start_job(14'd100, 14'd8);
        run_cycles(8);
        check("t3_we_mid",   32'(bus.mem_we), 32'd1);
        check("t3_addr_mid", 32'(bus.mem_addr), 32'd100);
        run_cycles(12);
        check("t3_acks_full", 32'(ack_cnt - a0), 32'd4);
        check("t3_we_held",   32'(bus.mem_we), 32'd1);
        check("t3_addr_held", 32'(bus.mem_addr), 32'd100);
        check("t3_data_held", bus.mem_wdata, 32'h100);
        bus.mem_gnt = 1'b1;
        wait_done(200);
        run_cycles(3);
        check("t3_acks", 32'(ack_cnt - a0), 32'd8);
        check("t3_dones", 32'(done_cnt - d0), 32'd1);
        check("t3_nwr", 32'(wa_q.size() - w0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t3_addr", 32'(wa_q[w0 + i]), 32'd100 + 32'(i));
            check("t3_data", wd_q[w0 + i], 32'h100 + 32'(i));
        end

        // Address wrap.
        px[0] = 32'd1; px[1] = 32'd2; px[2] = 32'd3; px_n = 3; px_idx = 0;
        w0 = wa_q.size();
        start_job(14'd16382, 14'd3);
        wait_done(100);
        run_cycles(2);
        check("t4_nwr", 32'(wa_q.size() - w0), 32'd3);
        check("t4_addr0", 32'(wa_q[w0]), 32'd16382);
        check("t4_addr1", 32'(wa_q[w0 + 1]), 32'd16383);
        check("t4_addr2", 32'(wa_q[w0 + 2]), 32'd0);

        // Reset in the middle of a job.
        for (int i = 0; i < 6; i++) px[i] = 32'hA0 + 32'(i);
        px_n = 6; px_idx = 0;
        w0 = wa_q.size();
        start_job(14'd200, 14'd6);
        for (int n = 0; n < 100 && wa_q.size() - w0 < 2; n++) run_cycles(1);
        check("t5_two_writes", 32'(wa_q.size() - w0), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_we",   32'(bus.mem_we), 32'd0);
        check("t5_rst_ack",  32'(bus.ack), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("t5_rst_data", bus.mem_wdata, 32'd0);
        px_n = 0; px_idx = 0; bus.pix_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wa_q.size();
        run_cycles(10);
        check("t5_no_writes", 32'(wa_q.size() - w0), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        px[0] = 32'd9; px[1] = 32'd10; px_n = 2; px_idx = 0;
        start_job(14'd300, 14'd2);
        wait_done(100);
        run_cycles(2);
        check("t5_new_nwr", 32'(wa_q.size() - w0), 32'd2);
        check("t5_new_a0", 32'(wa_q[w0]), 32'd300);
        check("t5_new_d0", wd_q[w0], 32'd9);
        check("t5_new_a1", 32'(wa_q[w0 + 1]), 32'd301);
        check("t5_new_d1", wd_q[w0 + 1], 32'd10);

        // Sign handling at capture.
`ifdef PIXEL_WRITER_RELU_EN
        relu_exp0 = 32'h0000_0000;
`else
        relu_exp0 = 32'hFFFF_FFF0;
`endif
        px[0] = 32'hFFFF_FFF0; px[1] = 32'h0000_0010; px_n = 2; px_idx = 0;
        w0 = wa_q.size();
        start_job(14'd400, 14'd2);
        wait_done(100);
        run_cycles(2);
        check("t6_nwr", 32'(wa_q.size() - w0), 32'd2);
        check("t6_neg", wd_q[w0], relu_exp0);
        check("t6_pos", wd_q[w0 + 1], 32'h0000_0010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pixel_result_writer

// File: doc/pixel_result_writer.md
Name: pixel_result_writer

Overview:
- Downstream stage of the pixel point processor.
- Consumes each finished 32-bit pixel via the processor's done/ack handshake and buffers it in a small FIFO.
- Writes pixels to sequential result-memory addresses starting at result_addr.
- Signals completion when a programmed number of pixels has been committed to memory.

Parameters:
DATA_W, 32, pixel width (matches out_pix)
ADDR_W, 14, memory address width (matches result_addr)
FIFO_DEPTH, 4, buffered pixels; power of two, >=2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; launches a job when idle
result_addr  input  ADDR_W  first write address, latched on start
pix_count  input  ADDR_W  pixels in job, latched on start
pix_data  input  DATA_W  pixel from processor (out_pix)
pix_done  input  1  processor has a valid pixel; held until ack
ack  output  1  one-cycle pulse: pixel captured
mem_we  output  1  write request, held until granted
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
mem_gnt  input  1  memory accepted the write on this edge when mem_we=1
busy  output  1  job in progress
done  output  1  one-cycle pulse: all pixels written

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FIFO empty; counters 0; FSM in IDLE. Reset mid-job abandons the job with no further writes.
- IDLE state:
  - start latches result_addr into wr_addr and pix_count into remaining counters.
  - If pix_count != 0, go to RUN and set busy=1 on the next cycle.
  - If pix_count == 0, go to FIN.
- start outside IDLE is ignored.
- Capture (RUN only):
  - At an edge where pix_done=1, ack=0, FIFO not full and cap_left != 0: push pix_data, decrement cap_left, and register ack=1 for exactly one cycle.
  - While ack=1, no capture occurs, which prevents a double take before upstream drops pix_done.
  - "Full" is evaluated before the same-edge pop, so a full FIFO never pushes, even if it pops on that edge.
  - pix_done is ignored once cap_left=0.
- Write port:
  - When the FIFO is non-empty and no write is pending, register mem_we=1, mem_addr=wr_addr and mem_wdata=FIFO head.
  - The pending write completes at an edge with mem_we=1 and mem_gnt=1. On that edge: pop, wr_addr+1, wr_left-1.
  - On the completing edge, if another entry is available, present it immediately. Throughput is one write per cycle with mem_gnt tied high.
  - mem_addr, mem_wdata and mem_we are stable while mem_gnt=0.
  - wr_addr wraps modulo 2^ADDR_W (16383 -> 0) with no error.
- Latency: pix_done rising in RUN with an empty FIFO gives ack at +1 cycle and mem_we at +2 cycles.
- FIN state: entered from RUN when wr_left reaches 0 on a write completion. In FIN: done=1 and busy=0 for one cycle, then return to IDLE.
- Simultaneous push and pop on a non-full FIFO: both happen and occupancy is unchanged.
- FSM states: IDLE -> RUN -> FIN -> IDLE; IDLE -> FIN directly when pix_count=0.

Optional Feature:
- Macro: PIXEL_WRITER_RELU_EN.
- Defined: ReLU is applied at FIFO push, so pix_data interpreted as signed two's complement is stored as 0 when bit DATA_W-1 = 1; otherwise it is stored unchanged.
- Undefined: pix_data is stored bit-exact.
- Timing and handshake are identical in both cases.

Decomposition:
- Shared package nh_pkg holds:
  - width constants PIX_W=32 and MEM_ADDR_W=14
  - writer FSM state typedef {IDLE, RUN, FIN}
- One sub-module, pixel_wb_fifo: synchronous FIFO with push, pop, full, empty and head data. Parameters DATA_W and FIFO_DEPTH.
- The FSM, handshake and write port stay in pixel_result_writer.

Test Plan:
- start, result_addr=10000, pix_count=3, mem_gnt=1, pixels 5/6/7 each held until ack -> exactly 3 ack pulses; writes (10000,5), (10001,6), (10002,7); one done pulse; busy=0 afterwards.
- pix_count=0 -> done pulse 2 cycles after start; no ack, no mem_we.
- mem_gnt=0 for 20 cycles with pix_done continuously offered, count=8 -> exactly 4 acks (FIFO full), mem_we held with addr/data stable; after releasing mem_gnt, all 8 written in order; done pulse.
- result_addr=16382, count=3 -> writes at 16382, 16383, 0.
- rst_n low mid-job after 2 writes -> all outputs 0 asynchronously; after release, no writes until a new start; a new job runs cleanly.
- PIXEL_WRITER_RELU_EN defined, pixels 0xFFFFFFF0 and 0x00000010 -> written 0x00000000 and 0x00000010. Undefined -> written unchanged.
